btb_predictor: RTL and testbench

- Direct-mapped branch target buffer with a 2-bit saturating direction counter per entry.
- Serves the IF stage of the pipelined LEGv8 core: the fetch PC is looked up combinationally, and the block predicts next-PC as taken-target or PC+4.
- Trained from resolved branches in EX/MEM.
- Replaces the fixed "always not-taken, resolve in MEM" policy, adding entry count, tag width and statistics width parameters plus mispredict accounting.

---
 rtl/btb_predictor.sv | 107 ++++++++++
 tb/tb_btb_predictor.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters for IF-stage next-PC prediction.
// Trained from resolved EX/MEM branches; keeps saturating update/mispredict statistics.
module btb_predictor #(
   parameter int unsigned ADDR_W   = 64,
   parameter int unsigned IDX_W    = 4,
   parameter int unsigned TAG_W    = 8,
   parameter logic [1:0]  CTR_INIT = 2'b10,
   parameter int unsigned STAT_W   = 32
) (
   input  logic              clk,
   input  logic              nreset,
   input  logic [ADDR_W-1:0] lookup_pc,
   output logic              pred_taken,
   output logic [ADDR_W-1:0] pred_target,
   input  logic              upd_valid,
   input  logic [ADDR_W-1:0] upd_pc,
   input  logic              upd_taken,
   input  logic [ADDR_W-1:0] upd_target,
   input  logic              upd_uncond,
   input  logic              upd_pred_taken,
   input  logic [ADDR_W-1:0] upd_pred_target,
   input  logic              flush_all,
   output logic              mispredict,
   output logic [STAT_W-1:0] stat_updates,
   output logic [STAT_W-1:0] stat_mispredicts
);
   localparam int unsigned ENTRIES = 2 ** IDX_W;
   localparam int unsigned TAG_LSB = IDX_W + 2;
   localparam int unsigned TAG_MSB = IDX_W + TAG_W + 1;

   logic [ENTRIES-1:0] valid;
   logic [TAG_W-1:0]   tag_mem [ENTRIES];
   logic [ADDR_W-1:0]  tgt_mem [ENTRIES];
   logic [1:0]         ctr_mem [ENTRIES];

   logic [IDX_W-1:0] l_idx;
   logic [IDX_W-1:0] u_idx;
   logic [TAG_W-1:0] l_tag;
   logic [TAG_W-1:0] u_tag;
   logic             l_hit;
   logic             u_hit;
   logic             u_wrong;
   logic             train;
   logic             unused_pc_bits;

   assign l_idx = lookup_pc[TAG_LSB-1:2];
   assign l_tag = lookup_pc[TAG_MSB:TAG_LSB];
   assign u_idx = upd_pc[TAG_LSB-1:2];
   assign u_tag = upd_pc[TAG_MSB:TAG_LSB];
   assign unused_pc_bits = ^{upd_pc[ADDR_W-1:TAG_MSB+1], upd_pc[1:0]};

   // Combinational fetch-side lookup
   assign l_hit       = valid[l_idx] && (tag_mem[l_idx] == l_tag);
   assign pred_taken  = l_hit && ctr_mem[l_idx][1];
   assign pred_target = pred_taken ? tgt_mem[l_idx] : lookup_pc + ADDR_W'(4);

   assign u_hit   = valid[u_idx] && (tag_mem[u_idx] == u_tag);
   assign u_wrong = (upd_pred_taken != upd_taken) ||
                    (upd_taken && (upd_pred_target != upd_target));
   assign train   = nreset && upd_valid && !flush_all;

   always_ff @(posedge clk) begin
      if (!nreset) begin
         valid <= '0;
      end else if (flush_all) begin
         valid <= '0;
      end else if (upd_valid && !u_hit && upd_taken) begin
         valid[u_idx] <= 1'b1;
      end
   end

   // Entry payload carries no reset; it is only observed through valid
   always_ff @(posedge clk) begin
      if (train) begin
         if (u_hit) begin
            if (upd_uncond) begin
               ctr_mem[u_idx] <= 2'b11;
               tgt_mem[u_idx] <= upd_target;
            end else if (upd_taken) begin
               if (ctr_mem[u_idx] != 2'b11) ctr_mem[u_idx] <= ctr_mem[u_idx] + 2'd1;
               tgt_mem[u_idx] <= upd_target;
            end else if (ctr_mem[u_idx] != 2'b00) begin
               ctr_mem[u_idx] <= ctr_mem[u_idx] - 2'd1;
            end
         end else if (upd_taken) begin
            tag_mem[u_idx] <= u_tag;
            tgt_mem[u_idx] <= upd_target;
            ctr_mem[u_idx] <= upd_uncond ? 2'b11 : CTR_INIT;
         end
      end
   end

   // Mispredict flag and saturating statistics count even during a flush
   always_ff @(posedge clk) begin
      if (!nreset) begin
         mispredict       <= 1'b0;
         stat_updates     <= '0;
         stat_mispredicts <= '0;
      end else begin
         mispredict <= upd_valid && u_wrong;
         if (upd_valid && (stat_updates != '1))
            stat_updates <= stat_updates + STAT_W'(1);
         if (upd_valid && u_wrong && (stat_mispredicts != '1))
            stat_mispredicts <= stat_mispredicts + STAT_W'(1);
      end
   end
endmodule

// File: tb/tb_btb_predictor.sv
// Bench for btb_predictor: directed vector table, hand sequences and random traffic vs a reference model.
module tb_btb_predictor;
   typedef struct {
      logic [63:0] lpc;
      bit          uv;
      logic [63:0] upc;
      bit          ut;
      logic [63:0] utgt;
      bit          uu;
      bit          upt;
      logic [63:0] uptgt;
      bit          fl;
      bit          rst;
      bit          e_pt;
      logic [63:0] e_tgt;
      bit          e_mis;
   } vec_t;

   logic        clk = 1'b0;
   logic        nreset;
   logic [63:0] lookup_pc, upd_pc, upd_target, upd_pred_target;
   logic        upd_valid, upd_taken, upd_uncond, upd_pred_taken, flush_all;
   logic        pred_taken, mispredict, p4_taken, mis4;
   logic [63:0] pred_target, p4_target;
   logic [31:0] stat_updates, stat_mispredicts;
   logic [3:0]  su4, sm4;

   int n_pass = 0;
   int n_total = 0;

   bit          m_valid [16];
   logic [7:0]  m_tag [16];
   logic [63:0] m_tgt [16];
   int          m_ctr [16];
   longint      m_upd, m_mis;
   bit          m_mis_out;

   vec_t tbl [19];

   always #5 clk = ~clk;

   btb_predictor dut (
      .clk(clk), .nreset(nreset), .lookup_pc(lookup_pc),
      .pred_taken(pred_taken), .pred_target(pred_target),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
      .upd_target(upd_target), .upd_uncond(upd_uncond),
      .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
      .flush_all(flush_all), .mispredict(mispredict),
      .stat_updates(stat_updates), .stat_mispredicts(stat_mispredicts));

   btb_predictor #(.STAT_W(4)) dut4 (
      .clk(clk), .nreset(nreset), .lookup_pc(lookup_pc),
      .pred_taken(p4_taken), .pred_target(p4_target),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
      .upd_target(upd_target), .upd_uncond(upd_uncond),
      .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
      .flush_all(flush_all), .mispredict(mis4),
      .stat_updates(su4), .stat_mispredicts(sm4));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      else n_pass++;
   endtask

   function automatic longint sat(input longint cnt, input int w);
      longint mx;
      mx = (longint'(1) << w) - 1;
      return (cnt > mx) ? mx : cnt;
   endfunction

   // Reference: entry = pc[5:2], tag = pc[13:6], taken when counter >= 2
   task automatic model_lookup(input logic [63:0] pc, output bit pt, output logic [63:0] tgt);
      int i;
      i = int'(pc[5:2]);
      pt = m_valid[i] && (m_tag[i] == pc[13:6]) && (m_ctr[i] >= 2);
      tgt = pt ? m_tgt[i] : pc + 64'd4;
   endtask

   task automatic model_step(input vec_t v);
      int  i;
      bit  hit, wrong;
      if (v.rst) begin
         foreach (m_valid[k]) m_valid[k] = 1'b0;
         m_upd = 0; m_mis = 0; m_mis_out = 1'b0;
         return;
      end
      wrong = (v.upt != v.ut) || (v.ut && (v.uptgt != v.utgt));
      m_mis_out = v.uv && wrong;
      if (v.uv) begin
         m_upd++;
         if (wrong) m_mis++;
      end
      if (v.fl) begin
         foreach (m_valid[k]) m_valid[k] = 1'b0;
         return;
      end
      if (!v.uv) return;
      i = int'(v.upc[5:2]);
      hit = m_valid[i] && (m_tag[i] == v.upc[13:6]);
      if (hit) begin
         if (v.uu) begin
            m_ctr[i] = 3; m_tgt[i] = v.utgt;
         end else if (v.ut) begin
            m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3; m_tgt[i] = v.utgt;
         end else begin
            m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
         end
      end else if (v.ut) begin
         m_valid[i] = 1'b1; m_tag[i] = v.upc[13:6]; m_tgt[i] = v.utgt;
         m_ctr[i] = v.uu ? 3 : 2;
      end
   endtask

   task automatic run_cycle(input vec_t v, input bit use_exp, input string nm);
      bit          ept;
      logic [63:0] etgt;
      lookup_pc = v.lpc; upd_valid = v.uv; upd_pc = v.upc; upd_taken = v.ut;
      upd_target = v.utgt; upd_uncond = v.uu; upd_pred_taken = v.upt;
      upd_pred_target = v.uptgt; flush_all = v.fl; nreset = !v.rst;
      model_lookup(v.lpc, ept, etgt);
      @(negedge clk);
      chk({nm, ".pt"}, 64'(pred_taken), 64'(ept));
      chk({nm, ".tgt"}, pred_target, etgt);
      chk({nm, ".pt4"}, 64'(p4_taken), 64'(ept));
      if (use_exp) begin
         chk({nm, ".pt_tbl"}, 64'(pred_taken), 64'(v.e_pt));
         chk({nm, ".tgt_tbl"}, pred_target, v.e_tgt);
      end
      @(posedge clk);
      model_step(v);
      #1;
      chk({nm, ".mis"}, 64'(mispredict), 64'(m_mis_out));
      chk({nm, ".mis4"}, 64'(mis4), 64'(m_mis_out));
      chk({nm, ".su"}, 64'(stat_updates), 64'(sat(m_upd, 32)));
      chk({nm, ".sm"}, 64'(stat_mispredicts), 64'(sat(m_mis, 32)));
      chk({nm, ".su4"}, 64'(su4), 64'(sat(m_upd, 4)));
      chk({nm, ".sm4"}, 64'(sm4), 64'(sat(m_mis, 4)));
      if (use_exp) chk({nm, ".mis_tbl"}, 64'(mispredict), 64'(v.e_mis));
   endtask

   function automatic logic [63:0] rpc();
      logic [63:0] p;
      p = (64'($urandom_range(0, 3)) << 6) | (64'($urandom_range(0, 15)) << 2) |
          64'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) p = p | {32'($urandom), 18'($urandom), 14'h0};
      return p;
   endfunction

   initial begin
      vec_t v, rv;
      // lpc, uv, upc, ut, utgt, uu, upt, uptgt, fl, rst, e_pt, e_tgt, e_mis
      tbl[0]  = '{64'h40, 0, 64'h0, 0, 64'h0, 0, 0, 64'h0, 0, 1, 0, 64'h44, 0};
      tbl[1]  = '{64'h40, 1, 64'h40, 1, 64'h100, 0, 0, 64'h0, 0, 0, 0, 64'h44, 1};
      tbl[2]  = '{64'h40, 0, 64'h0, 0, 64'h0, 0, 0, 64'h0, 0, 0, 1, 64'h100, 0};
      tbl[3]  = '{64'h40, 1, 64'h40, 0, 64'h0, 0, 1, 64'h100, 0, 0, 1, 64'h100, 1};
      tbl[4]  = '{64'h40, 1, 64'h40, 0, 64'h0, 0, 0, 64'h0, 0, 0, 0, 64'h44, 0};
      tbl[5]  = '{64'h40, 1, 64'h40, 0, 64'h0, 0, 0, 64'h0, 0, 0, 0, 64'h44, 0};
      tbl[6]  = '{64'h40, 1, 64'h40, 1, 64'h100, 0, 0, 64'h0, 0, 0, 0, 64'h44, 1};
      tbl[7]  = '{64'h40, 0, 64'h0, 0, 64'h0, 0, 0, 64'h0, 0, 0, 0, 64'h44, 0};
      tbl[8]  = '{64'h40, 1, 64'h40, 1, 64'h100, 0, 0, 64'h0, 0, 0, 0, 64'h44, 1};
      tbl[9]  = '{64'h40, 0, 64'h0, 0, 64'h0, 0, 0, 64'h0, 0, 0, 1, 64'h100, 0};
      tbl[10] = '{64'h40, 1, 64'h440, 1, 64'h300, 0, 0, 64'h0, 0, 0, 1, 64'h100, 1};
      tbl[11] = '{64'h40, 1, 64'h80, 0, 64'h0, 0, 0, 64'h0, 0, 0, 0, 64'h44, 0};
      tbl[12] = '{64'h440, 0, 64'h0, 0, 64'h0, 0, 0, 64'h0, 0, 0, 1, 64'h300, 0};
      tbl[13] = '{64'h80, 0, 64'h0, 0, 64'h0, 0, 0, 64'h0, 0, 0, 0, 64'h84, 0};
      tbl[14] = '{64'h84, 1, 64'h84, 1, 64'h200, 1, 0, 64'h0, 0, 0, 0, 64'h88, 1};
      tbl[15] = '{64'h84, 1, 64'h84, 0, 64'h0, 0, 1, 64'h200, 0, 0, 1, 64'h200, 1};
      tbl[16] = '{64'h84, 1, 64'h84, 0, 64'h0, 0, 1, 64'h200, 0, 0, 1, 64'h200, 1};
      tbl[17] = '{64'h84, 0, 64'h0, 0, 64'h0, 0, 0, 64'h0, 0, 0, 0, 64'h88, 0};
      tbl[18] = '{64'hFFFF_FFFF_FFFF_FFFE, 0, 64'h0, 0, 64'h0, 0, 0, 64'h0, 0, 0, 0, 64'h2, 0};

      nreset = 1'b0; lookup_pc = '0; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
      upd_target = '0; upd_uncond = 1'b0; upd_pred_taken = 1'b0; upd_pred_target = '0;
      flush_all = 1'b0;
      repeat (2) @(posedge clk);
      model_step(tbl[0]);
      #1;

      for (int i = 0; i < 19; i++) run_cycle(tbl[i], 1'b1, $sformatf("tbl%0d", i));

      // Statistics saturation in the narrow instance
      v = '{64'h40, 1, 64'h100, 0, 64'h0, 0, 1, 64'h0, 0, 0, 0, 64'h44, 1};
      for (int i = 0; i < 20; i++) run_cycle(v, 1'b1, "satmis");
      chk("sat.su4", 64'(su4), 64'hF);
      chk("sat.sm4", 64'(sm4), 64'hF);

      // Flush with a coincident taken update: counted but not allocated
      v = '{64'h440, 1, 64'hC0, 1, 64'h500, 0, 0, 64'h0, 1, 0, 1, 64'h300, 1};
      run_cycle(v, 1'b1, "flush");
      chk("flush.su4", 64'(su4), 64'hF);
      v = '{64'h40, 0, 64'h0, 0, 64'h0, 0, 0, 64'h0, 0, 0, 0, 64'h44, 0};
      run_cycle(v, 1'b1, "fl40");
      v.lpc = 64'hC0;  v.e_tgt = 64'hC4;  run_cycle(v, 1'b1, "flC0");
      v.lpc = 64'h440; v.e_tgt = 64'h444; run_cycle(v, 1'b1, "fl440");
      v.lpc = 64'h84;  v.e_tgt = 64'h88;  run_cycle(v, 1'b1, "fl84");

      // Mid-stream reset discards a coincident allocating update
      v = '{64'h84, 1, 64'h40, 1, 64'h700, 0, 0, 64'h0, 0, 1, 0, 64'h88, 0};
      run_cycle(v, 1'b1, "rst");
      chk("rst.su", 64'(stat_updates), 64'h0);
      chk("rst.sm4", 64'(sm4), 64'h0);
      v = '{64'h40, 0, 64'h0, 0, 64'h0, 0, 0, 64'h0, 0, 0, 0, 64'h44, 0};
      run_cycle(v, 1'b1, "rst40");

      for (int n = 0; n < 3000; n++) begin
         rv.uv = ($urandom_range(0, 3) != 0);
         rv.upc = rpc();
         rv.ut = $urandom_range(0, 1) == 1;
         rv.uu = ($urandom_range(0, 5) == 0);
         rv.utgt = {$urandom, $urandom};
         if ($urandom_range(0, 1) == 1) begin
            model_lookup(rv.upc, rv.upt, rv.uptgt);
         end else begin
            rv.upt = $urandom_range(0, 1) == 1;
            rv.uptgt = ($urandom_range(0, 1) == 1) ? rv.utgt : {$urandom, $urandom};
         end
         rv.lpc = ($urandom_range(0, 3) == 0) ? rv.upc : rpc();
         rv.fl = ($urandom_range(0, 99) == 0);
         rv.rst = ($urandom_range(0, 199) == 0);
         rv.e_pt = 1'b0; rv.e_tgt = '0; rv.e_mis = 1'b0;
         run_cycle(rv, 1'b0, "rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
